// File: rtl/risc_datapath.sv
// risc_datapath: execution side of the RISC controller. It holds the register file, ALU,
// data RAM and Z flag, and commits one instruction per fetch/execute pair.
module risc_datapath #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RAM_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Rd,
    input  logic [3:0]        Rs,
    input  logic [3:0]        Rt,
    input  logic [3:0]        OP,
    input  logic              writeregister,
    input  logic              writeram,
    input  logic              readram,
    input  logic [1:0]        MUX2sel,
    input  logic [7:0]        offset,
    output logic [DATA_W-1:0] RegA,
    output logic              Z,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned RamDepth = 1 << RAM_AW;

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [DATA_W-1:0] ram_q  [RamDepth];
    logic [DATA_W-1:0] ram_d  [RamDepth];
    logic              z_q, z_d;
    logic              phase_q, phase_d;
    logic              primed_q, primed_d;

    logic              commit;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] alu_res, ram_rd, off_ext, wb;
    logic [RAM_AW-1:0] addr;

    // Selection between RAM and ALU is made by MUX2sel alone; readram carries no function here.
    logic unused_readram;
    assign unused_readram = readram;

    // R0 is never written, so it always reads back its reset value of zero.
    assign rs_val   = regs_q[Rs];
    assign rt_val   = regs_q[Rt];
    assign RegA     = rs_val;
    assign dbg_data = regs_q[dbg_sel];
    assign Z        = z_q;

    assign addr    = rs_val[RAM_AW-1:0];
    assign ram_rd  = ram_q[addr];
    assign off_ext = DATA_W'(offset);

    // Commit only on the execute edge of the controller cadence, once fetch has been seen.
    assign commit = ~phase_q & primed_q;

    // ALU: opcodes 8-15 are unused and yield zero.
    always_comb begin
        alu_res = '0;
        case (OP)
            4'd0:    alu_res = rs_val + rt_val;
            4'd1:    alu_res = rs_val - rt_val;
            4'd2:    alu_res = rs_val & rt_val;
            4'd3:    alu_res = rs_val | rt_val;
            4'd4:    alu_res = rs_val ^ rt_val;
            4'd5:    alu_res = ~rs_val;
            4'd6:    alu_res = rs_val << 1;
            4'd7:    alu_res = rs_val >> 1;
            default: alu_res = '0;
        endcase
    end

    // Writeback source select.
    always_comb begin
        wb = off_ext;
        case (MUX2sel)
            2'd0:    wb = alu_res;
            2'd1:    wb = ram_rd;
            default: wb = off_ext;
        endcase
    end

    // Next-state: phase tracking plus register/RAM/Z updates gated by the commit edge.
    always_comb begin
        phase_d  = ~phase_q;
        primed_d = primed_q | phase_q;
        regs_d   = regs_q;
        ram_d    = ram_q;
        z_d      = z_q;
        if (commit) begin
            if (writeregister && (Rd != 4'd0)) begin
                regs_d[Rd] = wb;
                z_d        = (wb == '0);
            end
            // Store data comes from pre-commit register values.
            if (writeram) begin
                ram_d[addr] = rt_val;
            end
        end
    end

    // State registers; reset clears everything including RAM contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= 1'b0;
            primed_q <= 1'b0;
            z_q      <= 1'b0;
            regs_q   <= '{default: '0};
            ram_q    <= '{default: '0};
        end else begin
            phase_q  <= phase_d;
            primed_q <= primed_d;
            z_q      <= z_d;
            regs_q   <= regs_d;
            ram_q    <= ram_d;
        end
    end

endmodule

// File: doc/risc_datapath.md
# risc_datapath

Execution-side responder for the RISC controller's control bus. It receives Rd/Rs/Rt/OP/MUX2sel/offset and write/read strobes, and owns the architectural state: a 16x16 register file, ALU, 64-word data RAM and the Z flag. It returns RegA (the Rs read value) and Z, which the controller uses for jump-register and conditional branches. It tracks the controller's two-phase fetch/execute cadence so that each issued instruction commits exactly once.

## Interface
- DATA_W, 16, register/ALU/RAM word width
- RAM_AW, 6, data RAM address width (64 words)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- Rd, Rs, Rt  in  4 each  destination and source register indices
- OP  in  4  opcode
- writeregister  in  1  register-file write enable
- writeram  in  1  data RAM write enable
- readram  in  1  data RAM read select
- MUX2sel  in  2  writeback select
- offset  in  8  immediate/link value, zero-extended to DATA_W
- RegA  out  16  combinational reg[Rs]
- Z  out  1  registered zero flag
- dbg_sel  in  4  debug read index
- dbg_data  out  16  combinational reg[dbg_sel]

## Operation
- Phase tracker: `phase` toggles every clock. `primed` is set on the first edge where phase==1.
- Commit edge: a rising edge with phase==0 && primed. All state updates happen only on commit edges. On every other edge, inputs are ignored.
- Register file: R0 reads 0, and writes to R0 are discarded. Reads are combinational.
- rs_d = reg[Rs], rt_d = reg[Rt]. RegA = rs_d.
- ALU result by OP, all arithmetic mod 2^16:
  - 0 ADD: rs_d+rt_d
  - 1 SUB: rs_d-rt_d
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~rs_d
  - 6 SHL: rs_d<<1
  - 7 SHR: rs_d>>1, logical
  - 8-15: result 0
- RAM: address = rs_d[5:0], upper bits ignored. Read is combinational.
- Writeback value (wb) by MUX2sel: 0 = ALU result, 1 = RAM[addr], 2 and 3 = {8'h00, offset}.
- On commit:
  - if writeregister && Rd!=0: reg[Rd] <= wb; Z <= (wb==0).
  - if writeram: RAM[addr] <= rt_d.
- Simultaneous writeregister and writeram: both take effect. The RAM write uses pre-commit register values.
- Store-then-load to the same address in consecutive instructions returns the stored data.
- readram has no side effects; the data path selection is made by MUX2sel only.
- A write with Rd==0 leaves Z unchanged.

## Timing
- Reset values:
  - all registers 0
  - RAM contents 0 (cleared by reset)
  - Z=0, phase=0, primed=0
  - RegA=0 and dbg_data=0 follow from the cleared registers
- Reset asserted mid-instruction aborts any pending commit. No partial write survives, and phase and primed restart.
- Cadence after reset release:
  - cycle 0 (controller fetch, phase 0): no commit.
  - cycle 1: phase 1; primed is set at the end of the cycle.
  - cycle 2: controls from the first decode are valid and commit at the end of the cycle.
  - Commits then repeat every 2 cycles.
- Latency:
  - the register result is visible on RegA/dbg_data in the cycle after the commit edge.
  - Z updates on that same edge, so the next decode sees it.
- Control inputs must be stable across the full phase-0 cycle. Changes during phase 1 have no effect.

## Test plan
- Reset, then 4 cycles with writeregister=1, Rd=3, MUX2sel=2, offset=8'h5A -> no commit before cycle 2; R3=16'h005A after the cycle-2 edge, Z=0; writes held into later phase-0 cycles rewrite the same value.
- R1=16'hFFFF, R2=1, OP=0, Rd=4, Rs=1, Rt=2 -> R4=0, Z=1. Then OP=1 (SUB), Rd=5, Rs=2, Rt=1 -> R5=16'h0002, Z=0.
- Writeregister with Rd=0, MUX2sel=2, offset=8'hFF -> dbg_data for R0 stays 0 and Z is unchanged.
- Store/load:
  - R6=16'h0047, R7=16'hBEEF; writeram=1, Rs=6, Rt=7 -> RAM[7]=16'hBEEF (address truncated to 6 bits).
  - Next instruction: MUX2sel=1, readram=1, Rd=8, Rs=6 -> R8=16'hBEEF.
- Shifts and NOT: R9=16'h8001; OP=6 -> 16'h0002; OP=7 -> 16'h4000; OP=5 -> 16'h7FFE.
- Assert reset during phase 0 with a pending write to R10 -> R10=0 and Z=0 after release, and the first commit occurs only at the cycle-2 edge.
